hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Consumer end of the decoder's Tuse/Tnew interface in the 5-stage pipeline.
- Takes the D-stage instruction's source registers with their Tuse, and its destination register with its E-entry Tnew.
- Internally tracks destination register and Tnew per stage through E, M and W.
- Produces the D-stage stall/freeze and the forwarding selects for D, E and M.

Parameters:
- REG_AW, 5, register address width; address 0 is never a hazard.
- TW, 2, Tuse/Tnew width; Tuse value 2'b11 means "operand unused".
- CNT_W, 32, stall counter width (only when the optional feature is enabled).

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- D_rs  in  REG_AW  D-stage rs field
- D_rt  in  REG_AW  D-stage rt field
- D_TuseRs  in  TW  cycles until rs is needed; 11 = unused
- D_TuseRt  in  TW  cycles until rt is needed; 11 = unused
- D_A3  in  REG_AW  D-stage destination register (0 if no write)
- D_Tnew  in  TW  Tnew the instruction will carry on entering E
- D_regWrite  in  1  D instruction writes the register file
- stall  out  1  freeze PC and F/D register; E receives a bubble
- D_fwdRs  out  2  00 regfile, 01 E, 10 M, 11 W
- D_fwdRt  out  2  same encoding as D_fwdRs
- E_fwdRs  out  2  00 pipeline value, 10 M, 11 W (01 never driven)
- E_fwdRt  out  2  same encoding as E_fwdRs
- M_fwdRt  out  1  1 = store data taken from W
- stall_cnt  out  CNT_W  only when STALL_CNT_EN is defined

Behaviour:
- State registers:
  - E stage: E_rs, E_rt, E_A3, E_Tnew.
  - M stage: M_rt, M_A3, M_Tnew.
  - W stage: W_A3, W_Tnew (always 0).
  - Every A3 is stored as 0 when its regWrite is 0.
- Reset: all stage registers go to 0, which is a bubble. Consequently stall=0, every fwd output is 0 and stall_cnt=0 in the cycle after reset is sampled. Reset asserted mid-stall or mid-sequence flushes all tracked state; no hazard survives it.
- Stall is combinational from D inputs and current E/M state:
  - rs hazard: D_rs≠0, D_TuseRs≠11, and either (D_rs==E_A3 and E_Tnew>D_TuseRs) or (D_rs==M_A3 and M_Tnew>D_TuseRs).
  - rt hazard: same rule using rt.
  - stall = rs hazard OR rt hazard.
  - W never causes a stall.
- Advance each cycle when not in reset:
  - E ← D fields (E_Tnew ← D_Tnew), or all zeros if stall=1 (bubble).
  - M ← E with M_Tnew = E_Tnew−1, saturating at 0.
  - W ← M with W_Tnew = 0.
- Forwarding is combinational; the nearest matching stage wins (priority E>M>W for D, M>W for E):
  - A stage is a source only if its A3≠0, A3 equals the reg, and its Tnew==0.
  - A matching stage with Tnew>0 blocks all older stages. Stall covers that case, so the fwd value is then don't-care but must not select an older stage.
  - D_fwdRs/Rt: sources E, M, W.
  - E_fwdRs/Rt: compare E_rs/E_rt against M, then W.
  - M_fwdRt: M_rt≠0 and M_rt==W_A3.
- Fwd outputs are evaluated even while stall=1; the datapath ignores them.
- Simultaneous rs and rt hazards produce a single stall. Consecutive stalls are allowed with no upper limit.

Optional Feature:
- Macro STALL_CNT_EN.
- Defined: stall_cnt increments by 1 on every clock edge where stall=1 and reset=0. It wraps modulo 2^CNT_W and clears on reset.
- Undefined: the stall_cnt port and counter are absent; all other behaviour is identical.

Test Plan:
- lw $1 (D_A3=1, D_Tnew=10), then add $2,$1,$1 (Tuse 01/01):
  - cycle 1: stall=1.
  - cycle 2: stall=0 (M_Tnew=1).
  - cycle 3: add in E, E_fwdRs=E_fwdRt=11.
- add $3 (Tnew 01), then beq $3,$0 (TuseRs 00):
  - cycle 1: stall=1.
  - cycle 2: stall=0, D_fwdRs=10.
- ori $4 then sw $4 (TuseRt 10) back-to-back:
  - no stall.
  - sw in E: E_fwdRt=10.
- Zero register and unused operands:
  - writer with D_A3=0 followed by a reader of $0 → stall=0, fwd=00.
  - lui (Tuse 11) after lw to same rs → no stall.
- Priority: two consecutive ori writes to $5, then add reading $5 → D_fwdRs=01 (E), not M.
- Reset and counter:
  - reset asserted during a stall → next cycle stall=0, all fwd=00.
  - with STALL_CNT_EN, three stalled cycles give stall_cnt=3, then 0 after reset.

Source files
------------

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Tuse/Tnew hazard unit for a 5-stage pipeline. Tracks the
//               destination register and remaining Tnew of the instructions
//               in E, M and W, raises the D-stage stall and produces the
//               forwarding selects for the D, E and M stages.
// Ports       : clk, reset           - clock, synchronous active-high reset
//               D_rs/D_rt            - D-stage source registers
//               D_TuseRs/D_TuseRt    - cycles until operand needed (11 = unused)
//               D_A3/D_Tnew/D_regWrite - D-stage destination, Tnew on E entry
//               stall                - freeze PC and F/D, bubble into E
//               D_fwdRs/D_fwdRt      - 00 regfile, 01 E, 10 M, 11 W
//               E_fwdRs/E_fwdRt      - 00 pipeline, 10 M, 11 W
//               M_fwdRt              - 1 = store data taken from W
//               stall_cnt            - stalled-cycle counter (STALL_CNT_EN)
// Options     : define STALL_CNT_EN to add the stall_cnt port and counter.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int REG_AW = 5,
    parameter int TW     = 2,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] D_rs,
    input  logic [REG_AW-1:0] D_rt,
    input  logic [TW-1:0]     D_TuseRs,
    input  logic [TW-1:0]     D_TuseRt,
    input  logic [REG_AW-1:0] D_A3,
    input  logic [TW-1:0]     D_Tnew,
    input  logic              D_regWrite,
    output logic              stall,
    output logic [1:0]        D_fwdRs,
    output logic [1:0]        D_fwdRt,
    output logic [1:0]        E_fwdRs,
    output logic [1:0]        E_fwdRt,
    output logic              M_fwdRt
`ifdef STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    localparam logic [TW-1:0] c_TUSE_NONE = '1;

    // Stage state. W Tnew is always 0, so only W_A3 is held.
    logic [REG_AW-1:0] r_E_rs, r_E_rt, r_E_A3;
    logic [TW-1:0]     r_E_Tnew;
    logic [REG_AW-1:0] r_M_rt, r_M_A3;
    logic [TW-1:0]     r_M_Tnew;
    logic [REG_AW-1:0] r_W_A3;

    logic w_haz_rs, w_haz_rt;

    // A source operand stalls when an in-flight writer of the same register
    // will not have its result ready by the time the operand is consumed.
    function automatic logic f_hazard(
        input logic [REG_AW-1:0] r,
        input logic [TW-1:0]     tuse,
        input logic [REG_AW-1:0] e_a3,
        input logic [TW-1:0]     e_tnew,
        input logic [REG_AW-1:0] m_a3,
        input logic [TW-1:0]     m_tnew
    );
        f_hazard = (r != '0) && (tuse != c_TUSE_NONE) &&
                   (((r == e_a3) && (e_tnew > tuse)) ||
                    ((r == m_a3) && (m_tnew > tuse)));
    endfunction

    // Nearest matching stage decides. A match whose value is not yet produced
    // (Tnew > 0) must shadow older stages, so it falls back to 00 rather than
    // letting a stale older copy be selected.
    function automatic logic [1:0] f_dfwd(
        input logic [REG_AW-1:0] r,
        input logic [REG_AW-1:0] e_a3,
        input logic [TW-1:0]     e_tnew,
        input logic [REG_AW-1:0] m_a3,
        input logic [TW-1:0]     m_tnew,
        input logic [REG_AW-1:0] w_a3
    );
        f_dfwd = 2'b00;
        if (r != '0) begin
            if (r == e_a3)      f_dfwd = (e_tnew == '0) ? 2'b01 : 2'b00;
            else if (r == m_a3) f_dfwd = (m_tnew == '0) ? 2'b10 : 2'b00;
            else if (r == w_a3) f_dfwd = 2'b11;
        end
    endfunction

    function automatic logic [1:0] f_efwd(
        input logic [REG_AW-1:0] r,
        input logic [REG_AW-1:0] m_a3,
        input logic [TW-1:0]     m_tnew,
        input logic [REG_AW-1:0] w_a3
    );
        f_efwd = 2'b00;
        if (r != '0) begin
            if (r == m_a3)      f_efwd = (m_tnew == '0) ? 2'b10 : 2'b00;
            else if (r == w_a3) f_efwd = 2'b11;
        end
    endfunction

    assign w_haz_rs = f_hazard(D_rs, D_TuseRs, r_E_A3, r_E_Tnew, r_M_A3, r_M_Tnew);
    assign w_haz_rt = f_hazard(D_rt, D_TuseRt, r_E_A3, r_E_Tnew, r_M_A3, r_M_Tnew);
    assign stall    = w_haz_rs | w_haz_rt;

    assign D_fwdRs = f_dfwd(D_rs, r_E_A3, r_E_Tnew, r_M_A3, r_M_Tnew, r_W_A3);
    assign D_fwdRt = f_dfwd(D_rt, r_E_A3, r_E_Tnew, r_M_A3, r_M_Tnew, r_W_A3);
    assign E_fwdRs = f_efwd(r_E_rs, r_M_A3, r_M_Tnew, r_W_A3);
    assign E_fwdRt = f_efwd(r_E_rt, r_M_A3, r_M_Tnew, r_W_A3);
    assign M_fwdRt = (r_M_rt != '0) && (r_M_rt == r_W_A3);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_E_rs   <= '0;
            r_E_rt   <= '0;
            r_E_A3   <= '0;
            r_E_Tnew <= '0;
            r_M_rt   <= '0;
            r_M_A3   <= '0;
            r_M_Tnew <= '0;
            r_W_A3   <= '0;
        end else begin
            if (stall) begin
                r_E_rs   <= '0;
                r_E_rt   <= '0;
                r_E_A3   <= '0;
                r_E_Tnew <= '0;
            end else begin
                r_E_rs   <= D_rs;
                r_E_rt   <= D_rt;
                // Non-writing instructions carry A3 = 0 so they never match.
                r_E_A3   <= D_regWrite ? D_A3 : '0;
                r_E_Tnew <= D_Tnew;
            end
            r_M_rt   <= r_E_rt;
            r_M_A3   <= r_E_A3;
            r_M_Tnew <= (r_E_Tnew == '0) ? '0 : r_E_Tnew - TW'(1);
            r_W_A3   <= r_M_A3;
        end
    end

`ifdef STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset)      r_stall_cnt <= '0;
        else if (stall) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Self-checking bench for hazard_scoreboard. Each scenario is a
//               short instruction sequence; the expected stall/forward vector
//               is pushed to a scoreboard when a row is driven and popped and
//               compared half a cycle later. Honours STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] turs;
        logic [1:0] turt;
        logic [4:0] a3;
        logic [1:0] tnew;
        logic       rw;
        logic       rst;
    } stim_t;

    typedef struct packed {
        logic [9:0] val;
        logic [9:0] mask;
    } exp_t;

    // Observed vector: {stall, D_fwdRs, D_fwdRt, E_fwdRs, E_fwdRt, M_fwdRt}
    localparam logic [9:0] MA    = 10'b1_11_11_11_11_1;
    localparam logic [9:0] MNOD  = 10'b1_00_00_11_11_1;
    localparam logic [9:0] MNORS = 10'b1_00_11_11_11_1;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] D_rs, D_rt, D_A3;
    logic [1:0] D_TuseRs, D_TuseRt, D_Tnew;
    logic       D_regWrite;
    logic       stall, M_fwdRt;
    logic [1:0] D_fwdRs, D_fwdRt, E_fwdRs, E_fwdRt;
`ifdef STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif
    logic [9:0] obs;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    hazard_scoreboard #(.REG_AW(5), .TW(2), .CNT_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .D_rs       (D_rs),
        .D_rt       (D_rt),
        .D_TuseRs   (D_TuseRs),
        .D_TuseRt   (D_TuseRt),
        .D_A3       (D_A3),
        .D_Tnew     (D_Tnew),
        .D_regWrite (D_regWrite),
        .stall      (stall),
        .D_fwdRs    (D_fwdRs),
        .D_fwdRt    (D_fwdRt),
        .E_fwdRs    (E_fwdRs),
        .E_fwdRt    (E_fwdRt),
        .M_fwdRt    (M_fwdRt)
`ifdef STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    assign obs = {stall, D_fwdRs, D_fwdRt, E_fwdRs, E_fwdRt, M_fwdRt};

    function automatic stim_t S(input logic [4:0] rs, input logic [4:0] rt,
                                input logic [1:0] turs, input logic [1:0] turt,
                                input logic [4:0] a3, input logic [1:0] tnew,
                                input logic rw, input logic rst);
        S = '{rs: rs, rt: rt, turs: turs, turt: turt, a3: a3, tnew: tnew, rw: rw, rst: rst};
    endfunction

    function automatic stim_t NOP();
        NOP = S(5'd0, 5'd0, 2'b11, 2'b11, 5'd0, 2'd0, 1'b0, 1'b0);
    endfunction

    task automatic apply(input stim_t s, input logic [9:0] ev, input logic [9:0] em);
        reset      = s.rst;
        D_rs       = s.rs;
        D_rt       = s.rt;
        D_TuseRs   = s.turs;
        D_TuseRt   = s.turt;
        D_A3       = s.a3;
        D_Tnew     = s.tnew;
        D_regWrite = s.rw;
        sb.push_back('{val: ev, mask: em});
    endtask

    task automatic do_reset();
        stim_t n;
        n = NOP();
        reset      = 1'b1;
        D_rs       = n.rs;
        D_rt       = n.rt;
        D_TuseRs   = n.turs;
        D_TuseRt   = n.turt;
        D_A3       = n.a3;
        D_Tnew     = n.tnew;
        D_regWrite = n.rw;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        do_reset();
        // a reader of $1 right after reset must see no hazard
        apply(S(5'd1, 5'd1, 2'd0, 2'd0, 5'd2, 2'd1, 1'b1, 1'b0), 10'b0, MA);
        @(negedge clk);
        e = sb.pop_front();
        n_checks++;
        if ((obs & e.mask) !== (e.val & e.mask)) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required %b", obs, e.val);
        end
`ifdef STALL_CNT_EN
        n_checks++;
        if (stall_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_stall_cnt: got %0d required 0", stall_cnt);
        end
`endif
        @(posedge clk);
        #1;
    endtask

    // lw $1 ; add $2,$1,$1 (held while stalled) ; nop
    task automatic test_load_use();
        stim_t st[4];
        logic [9:0] ev[4];
        logic [9:0] em[4];
        exp_t e;
        st = '{S(0, 0, 1, 3, 1, 2, 1, 0), S(1, 1, 1, 1, 2, 1, 1, 0),
               S(1, 1, 1, 1, 2, 1, 1, 0), NOP()};
        ev = '{10'b0, 10'b1_00_00_00_00_0, 10'b0, 10'b0_00_00_11_11_0};
        em = '{MA, MNOD, MA, MA};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply(st[i], ev[i], em[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if ((obs & e.mask) !== (e.val & e.mask)) begin
                n_fail++;
                $display("FAIL load_use[%0d]: got %b required %b mask %b", i, obs, e.val, e.mask);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // add $3 (Tnew 1) ; beq $3,$0 (Tuse 0)
    task automatic test_branch_fwd();
        stim_t st[3];
        logic [9:0] ev[3];
        logic [9:0] em[3];
        exp_t e;
        st = '{S(0, 0, 3, 3, 3, 1, 1, 0), S(3, 0, 0, 0, 0, 0, 0, 0),
               S(3, 0, 0, 0, 0, 0, 0, 0)};
        ev = '{10'b0, 10'b1_00_00_00_00_0, 10'b0_10_00_00_00_0};
        em = '{MA, MNORS, MA};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            apply(st[i], ev[i], em[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if ((obs & e.mask) !== (e.val & e.mask)) begin
                n_fail++;
                $display("FAIL branch_fwd[%0d]: got %b required %b mask %b", i, obs, e.val, e.mask);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // ori $4 ; sw $4 (Tuse rt 2) ; nop ; nop
    task automatic test_back_to_back();
        stim_t st[4];
        logic [9:0] ev[4];
        logic [9:0] em[4];
        exp_t e;
        st = '{S(0, 0, 1, 3, 4, 1, 1, 0), S(0, 4, 1, 2, 0, 0, 0, 0), NOP(), NOP()};
        ev = '{10'b0, 10'b0, 10'b0_00_00_00_10_0, 10'b0_00_00_00_00_1};
        em = '{MA, MA, MA, MA};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply(st[i], ev[i], em[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if ((obs & e.mask) !== (e.val & e.mask)) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got %b required %b mask %b", i, obs, e.val, e.mask);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // lw $0 ; read $0 ; non-writing A3=6 ; read $6 ; lw $7 ; lui (rs $7 unused)
    task automatic test_zero_unused();
        stim_t st[6];
        exp_t e;
        st = '{S(0, 0, 1, 3, 0, 2, 1, 0), S(0, 0, 0, 0, 5, 1, 1, 0),
               S(0, 0, 1, 3, 6, 2, 0, 0), S(6, 6, 0, 0, 0, 0, 0, 0),
               S(0, 0, 1, 3, 7, 2, 1, 0), S(7, 0, 3, 3, 8, 1, 1, 0)};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            apply(st[i], 10'b0, MA);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if ((obs & e.mask) !== (e.val & e.mask)) begin
                n_fail++;
                $display("FAIL zero_unused[%0d]: got %b required %b", i, obs, e.val);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // two Tnew-0 writes of $5 then a reader: E beats M. Then a Tnew-1 writer
    // of $5 in E must shadow the ready copy in W.
    task automatic test_priority();
        stim_t st[6];
        logic [9:0] ev[6];
        exp_t e;
        st = '{S(0, 0, 3, 3, 5, 0, 1, 0), S(0, 0, 3, 3, 5, 0, 1, 0),
               S(5, 0, 1, 3, 9, 1, 1, 0), S(0, 0, 1, 3, 5, 1, 1, 0),
               S(5, 0, 1, 3, 10, 1, 1, 0), NOP()};
        ev = '{10'b0, 10'b0, 10'b0_01_00_00_00_0, 10'b0_00_00_10_00_0,
               10'b0, 10'b0_00_00_10_00_0};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            apply(st[i], ev[i], MA);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if ((obs & e.mask) !== (e.val & e.mask)) begin
                n_fail++;
                $display("FAIL priority[%0d]: got %b required %b", i, obs, e.val);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // lw $1 ; add $1 (Tuse 0) stalls and reset is taken in that same cycle
    task automatic test_reset_mid_stall();
        stim_t st[3];
        logic [9:0] ev[3];
        logic [9:0] em[3];
        exp_t e;
        st = '{S(0, 0, 1, 3, 1, 2, 1, 0), S(1, 1, 0, 0, 2, 1, 1, 1),
               S(1, 1, 0, 0, 2, 1, 1, 0)};
        ev = '{10'b0, 10'b1_00_00_00_00_0, 10'b0};
        em = '{MA, MNOD, MA};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            apply(st[i], ev[i], em[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if ((obs & e.mask) !== (e.val & e.mask)) begin
                n_fail++;
                $display("FAIL reset_mid_stall[%0d]: got %b required %b mask %b", i, obs, e.val, e.mask);
            end
            @(posedge clk);
            #1;
        end
`ifdef STALL_CNT_EN
        n_checks++;
        if (stall_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_stall_cnt: got %0d required 0", stall_cnt);
        end
`endif
    endtask

    // lw $1 ; beq $1 (two stalls, then W forward) ; add $9 ; beq $9 (one stall)
    task automatic test_stall_count();
        stim_t st[7];
        logic [9:0] ev[7];
        logic [9:0] em[7];
        exp_t e;
        st = '{S(0, 0, 1, 3, 1, 2, 1, 0), S(1, 0, 0, 0, 0, 0, 0, 0),
               S(1, 0, 0, 0, 0, 0, 0, 0), S(1, 0, 0, 0, 0, 0, 0, 0),
               S(0, 0, 3, 3, 9, 1, 1, 0), S(9, 0, 0, 0, 0, 0, 0, 0),
               S(9, 0, 0, 0, 0, 0, 0, 0)};
        ev = '{10'b0, 10'b1_00_00_00_00_0, 10'b1_00_00_00_00_0,
               10'b0_11_00_00_00_0, 10'b0, 10'b1_00_00_00_00_0,
               10'b0_10_00_00_00_0};
        em = '{MA, MNORS, MNORS, MA, MA, MNORS, MA};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            apply(st[i], ev[i], em[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if ((obs & e.mask) !== (e.val & e.mask)) begin
                n_fail++;
                $display("FAIL stall_count[%0d]: got %b required %b mask %b", i, obs, e.val, e.mask);
            end
            @(posedge clk);
            #1;
        end
`ifdef STALL_CNT_EN
        n_checks++;
        if (stall_cnt !== 32'd3) begin
            n_fail++;
            $display("FAIL stall_cnt_three: got %0d required 3", stall_cnt);
        end
        do_reset();
        @(negedge clk);
        n_checks++;
        if (stall_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL stall_cnt_cleared: got %0d required 0", stall_cnt);
        end
        @(posedge clk);
        #1;
`endif
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_fwd();
        test_back_to_back();
        test_zero_unused();
        test_priority();
        test_reset_mid_stall();
        test_stall_count();
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
